// File: rtl/ext_arbiter.sv
// Two-requester round-robin arbiter feeding an immediate-extension unit.
// One operation in flight: IDLE grants, EXEC computes, DONE pulses valid/ack.
module ext_arbiter #(
  parameter int IMM_W = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [IMM_W-1:0] imm0,
  input  logic [1:0]       mode0,
  input  logic             req1,
  input  logic [IMM_W-1:0] imm1,
  input  logic [1:0]       mode1,
  output logic             ack0,
  output logic             ack1,
  output logic [OUT_W-1:0] result,
  output logic             valid,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic             grant_sel;
  logic             grant_id;
  logic             last_grant;
  logic [IMM_W-1:0] lat_imm;
  logic [1:0]       lat_mode;

  // Modes: zero-extend, sign-extend, branch offset (sext << 2), upper-immediate.
  function automatic logic [OUT_W-1:0] extend(input logic [IMM_W-1:0] imm,
                                              input logic [1:0]       mode);
    logic [OUT_W-1:0] sx;
    sx = {{(OUT_W-IMM_W){imm[IMM_W-1]}}, imm};
    case (mode)
      2'b00:   extend = {{(OUT_W-IMM_W){1'b0}}, imm};
      2'b01:   extend = sx;
      2'b10:   extend = {sx[OUT_W-3:0], 2'b00};
      2'b11:   extend = {imm, {(OUT_W-IMM_W){1'b0}}};
      default: extend = {OUT_W{1'b0}};
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // On a tie the requester that was not granted last wins.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    grant_sel = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          load      = 1'b1;
          state_nxt = EXEC;
          if (req0 && req1) begin
            grant_sel = ~last_grant;
          end else begin
            grant_sel = req1;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      EXEC:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_imm    <= {IMM_W{1'b0}};
      lat_mode   <= 2'b00;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      result     <= {OUT_W{1'b0}};
      valid      <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      if (load) begin
        grant_id <= grant_sel;
        lat_imm  <= grant_sel ? imm1 : imm0;
        lat_mode <= grant_sel ? mode1 : mode0;
      end
      // valid/ack are registered here so they are high exactly during DONE.
      if (state == EXEC) begin
        result <= extend(lat_imm, lat_mode);
        valid  <= 1'b1;
        ack0   <= ~grant_id;
        ack1   <= grant_id;
      end else begin
        valid <= 1'b0;
        ack0  <= 1'b0;
        ack1  <= 1'b0;
      end
      if (state == DONE) begin
        last_grant <= grant_id;
      end
    end
  end

endmodule

// File: tb/tb_ext_arbiter.sv
// Self-checking bench: cycle-level reference model plus directed literal checks.
module tb_ext_arbiter;
  logic        clk;
  logic        rst;
  logic        req0, req1;
  logic [15:0] imm0, imm1;
  logic [1:0]  mode0, mode1;
  logic        ack0, ack1, valid, busy;
  logic [31:0] result;

  int pass_cnt = 0;
  int total_cnt = 0;

  ext_arbiter #(.IMM_W(16), .OUT_W(32)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .imm0(imm0), .mode0(mode0),
    .req1(req1), .imm1(imm1), .mode1(mode1),
    .ack0(ack0), .ack1(ack1), .result(result), .valid(valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Extension computed arithmetically on the signed/unsigned value of imm.
  function automatic logic [31:0] model_ext(input logic [15:0] imm, input logic [1:0] mode);
    int s;
    s = imm[15] ? int'(imm) - 65536 : int'(imm);
    case (mode)
      2'd0:    return 32'(int'(imm));
      2'd1:    return 32'(s);
      2'd2:    return 32'(s * 4);
      default: return 32'(int'(imm) * 65536);
    endcase
  endfunction

  function automatic logic pick(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return (last == 1'b1) ? 1'b0 : 1'b1;
    return r1;
  endfunction

  // Reference model: m_cnt = cycles elapsed since the grant (0 = waiting).
  int          m_cnt;
  logic        m_last, m_id, m_valid, m_ack0, m_ack1;
  logic [31:0] m_val, m_result;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= 0; m_last <= 1'b1; m_id <= 1'b0; m_val <= 32'd0;
      m_valid <= 1'b0; m_ack0 <= 1'b0; m_ack1 <= 1'b0; m_result <= 32'd0;
    end else begin
      m_valid <= 1'b0; m_ack0 <= 1'b0; m_ack1 <= 1'b0;
      if (m_cnt == 0) begin
        if (req0 || req1) begin
          m_id  <= pick(req0, req1, m_last);
          m_val <= pick(req0, req1, m_last) ? model_ext(imm1, mode1) : model_ext(imm0, mode0);
          m_cnt <= 1;
        end
      end else if (m_cnt == 1) begin
        m_result <= m_val;
        m_valid  <= 1'b1;
        m_ack0   <= (m_id == 1'b0);
        m_ack1   <= (m_id == 1'b1);
        m_cnt    <= 2;
      end else begin
        m_last <= m_id;
        m_cnt  <= 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("valid", {31'd0, valid}, {31'd0, m_valid});
    chk("ack0", {31'd0, ack0}, {31'd0, m_ack0});
    chk("ack1", {31'd0, ack1}, {31'd0, m_ack1});
    chk("busy", {31'd0, busy}, {31'd0, (m_cnt != 0)});
    chk("result", result, m_result);
    chk("ack_excl", {31'd0, ack0 & ack1}, 32'd0);
  end

  task automatic wait_valid(output int cyc, output logic [31:0] r, output logic a0, output logic a1);
    cyc = 0; r = 32'd0; a0 = 1'b0; a1 = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!valid && cyc < 20);
    chk("valid_seen", {31'd0, valid}, 32'd1);
    r = result; a0 = ack0; a1 = ack1;
  endtask

  int          c;
  logic [31:0] r;
  logic        a0, a1;

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    imm0 = 16'h0000; imm1 = 16'h0000; mode0 = 2'b00; mode1 = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_result", result, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    // Single requester 0, sign-extend.
    req0 = 1'b1; imm0 = 16'h8001; mode0 = 2'b01;
    wait_valid(c, r, a0, a1);
    chk("t1_latency", c, 32'd2);
    chk("t1_result", r, 32'hFFFF8001);
    chk("t1_ack0", {31'd0, a0}, 32'd1);
    chk("t1_ack1", {31'd0, a1}, 32'd0);
    req0 = 1'b0;

    // Single requester 1, branch offsets.
    @(negedge clk);
    req1 = 1'b1; imm1 = 16'h0001; mode1 = 2'b10;
    wait_valid(c, r, a0, a1);
    chk("t2_result_a", r, 32'h00000004);
    chk("t2_ack0_a", {31'd0, a0}, 32'd0);
    chk("t2_ack1_a", {31'd0, a1}, 32'd1);
    req1 = 1'b0;
    @(negedge clk);
    req1 = 1'b1; imm1 = 16'hFFFF; mode1 = 2'b10;
    wait_valid(c, r, a0, a1);
    chk("t2_result_b", r, 32'hFFFFFFFC);
    req1 = 1'b0;

    // Tie after reset: requester 0 first, then pending requester 1.
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    req0 = 1'b1; imm0 = 16'h1234; mode0 = 2'b00;
    req1 = 1'b1; imm1 = 16'h1234; mode1 = 2'b11;
    wait_valid(c, r, a0, a1);
    chk("t3_result_a", r, 32'h00001234);
    chk("t3_ack0_a", {31'd0, a0}, 32'd1);
    req0 = 1'b0;
    wait_valid(c, r, a0, a1);
    chk("t3_result_b", r, 32'h12340000);
    chk("t3_ack1_b", {31'd0, a1}, 32'd1);
    chk("t3_ack0_b", {31'd0, a0}, 32'd0);
    req1 = 1'b0;

    // Operands and req change after grant.
    @(negedge clk);
    req0 = 1'b1; imm0 = 16'h00FF; mode0 = 2'b00;
    @(negedge clk);
    imm0 = 16'hAAAA; req0 = 1'b0;
    wait_valid(c, r, a0, a1);
    chk("t4_result", r, 32'h000000FF);
    chk("t4_ack0", {31'd0, a0}, 32'd1);

    // Reset during EXEC aborts the operation.
    @(negedge clk);
    req0 = 1'b1; imm0 = 16'h0005; mode0 = 2'b00;
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk("t5_result", result, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_valid", {31'd0, valid}, 32'd0);
    @(negedge clk); rst = 1'b0; req0 = 1'b0;
    repeat (3) @(negedge clk);
    req0 = 1'b1; imm0 = 16'h7FFF; mode0 = 2'b01;
    wait_valid(c, r, a0, a1);
    chk("t5_latency", c, 32'd2);
    chk("t5_result_after", r, 32'h00007FFF);
    req0 = 1'b0;

    // Both held continuously: alternate 0,1,0,1 every 3 cycles.
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    req0 = 1'b1; imm0 = 16'h0010; mode0 = 2'b00;
    req1 = 1'b1; imm1 = 16'h0020; mode1 = 2'b00;
    for (int i = 0; i < 4; i++) begin
      wait_valid(c, r, a0, a1);
      chk("t6_interval", c, (i == 0) ? 32'd2 : 32'd3);
      chk("t6_ack1", {31'd0, a1}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("t6_result", r, (i % 2 == 1) ? 32'h00000020 : 32'h00000010);
    end
    req0 = 1'b0; req1 = 1'b0;

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/ext_arbiter.md
EXT_ARBITER -- requirements
Module: ext_arbiter

Interface
REQ-001 Parameter IMM_W, default 16, immediate input width.
REQ-002 Parameter OUT_W, default 32, result width; SHALL be at least IMM_W+2.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req0  input  1  requester 0 request; held high until ack0.
REQ-006 imm0  input  IMM_W  requester 0 immediate; stable while req0 high.
REQ-007 mode0  input  2  requester 0 extension mode.
REQ-008 req1, imm1, mode1  input  1/IMM_W/2  requester 1, same rules as requester 0.
REQ-009 ack0, ack1  output  1  one-cycle completion pulse to the granted requester.
REQ-010 result  output  OUT_W  registered extended value.
REQ-011 valid  output  1  one-cycle pulse; result newly updated.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 Modes SHALL be: 00 zero-extend; 01 sign-extend; 10 sign-extend then shift left 2, low bits zero (branch offset); 11 imm placed at bits [OUT_W-1:OUT_W-IMM_W], low bits zero (upper-immediate load).
REQ-014 FSM states SHALL be IDLE, EXEC, DONE; encoding is free.
REQ-015 IDLE: no request -> stay IDLE; any request -> latch the winner's imm/mode and grant id, go EXEC.
REQ-016 EXEC: compute the extension of the latched operands into result, go DONE unconditionally.
REQ-017 DONE: valid=1 and ack of the granted requester =1 for exactly this cycle; update last-grant pointer; go IDLE.
REQ-018 Latency: a request sampled at IDLE edge E0 SHALL give valid/ack high between edges E1 and E2; the next request can be sampled no earlier than edge E3.
REQ-019 Single request: that requester SHALL win regardless of pointer.
REQ-020 Simultaneous req0 and req1 in IDLE: the requester NOT granted last SHALL win (round-robin); the loser stays pending and wins the next arbitration.
REQ-021 Operands SHALL be latched at the grant edge; changes to imm/mode/req after grant SHALL NOT affect the result.
REQ-022 A request dropped after grant SHALL still complete with valid and ack.
REQ-023 result SHALL hold its value outside DONE until the next DONE.
REQ-024 ack0 and ack1 SHALL never be high together; neither SHALL be high outside DONE.
REQ-025 A req still high in the IDLE cycle after DONE SHALL count as a new request.

Reset
REQ-026 rst high SHALL immediately force state IDLE, result=0, valid=0, ack0=ack1=0, busy=0, and the last-grant pointer to requester 1, so requester 0 wins the first tie.
REQ-027 rst asserted in EXEC or DONE SHALL abort the operation with no ack or valid issued; operation does not resume after release.
REQ-028 The first request SHALL be sampled at the first rising edge with rst low.

Verification
REQ-029 req0=1, imm0=16'h8001, mode0=01 -> two edges later valid=1, ack0=1, result=32'hFFFF8001; busy high for 2 cycles.
REQ-030 req1=1, imm1=16'h0001, mode1=10 -> result=32'h00000004, ack1 only; then imm1=16'hFFFF, mode1=10 -> result=32'hFFFFFFFC.
REQ-031 After reset, req0 and req1 both high together (imm0=16'h1234 mode 00, imm1=16'h1234 mode 11) -> first result 32'h00001234 with ack0, then 32'h12340000 with ack1; no ack overlap.
REQ-032 Grant req0 with imm0=16'h00FF mode 00, change imm0 to 16'hAAAA and drop req0 in EXEC -> result=32'h000000FF, ack0 still pulses.
REQ-033 rst pulsed during EXEC -> no valid/ack, result=0, busy=0; next req0 after release completes normally in 2 cycles.
REQ-034 Both requesters held high continuously for 4 operations -> grants alternate 0,1,0,1; valid pulses every 3 cycles.
